// File: rtl/gomoku_pkg.sv
// Shared gomoku definitions: board geometry, player encoding, FSM states
// and the row/col -> bit-index mapping used by the writer and the win checkers.
package gomoku_pkg;

    localparam int BOARD_N = 15;
    localparam int CELLS   = BOARD_N * BOARD_N;

    localparam logic PLAYER_BLACK = 1'b0;
    localparam logic PLAYER_WHITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Bit position of a cell in a player bitmap: row-major, 8-bit arithmetic.
    function automatic logic [7:0] cell_idx(input logic [3:0] row,
                                            input logic [3:0] col,
                                            input int         n = BOARD_N);
        return 8'(row) * 8'(n) + 8'(col);
    endfunction

endpackage

// File: rtl/gomoku_move_legal.sv
// Combinational move legality: coordinates on the board, correct player,
// and target cell empty in both bitmaps. Also returns the cell bit index.
module gomoku_move_legal
    import gomoku_pkg::*;
#(
    parameter int N = BOARD_N
) (
    input  logic [3:0]     row,
    input  logic [3:0]     col,
    input  logic           player,
    input  logic           turn,
    input  logic [N*N-1:0] board_black,
    input  logic [N*N-1:0] board_white,
    output logic           legal,
    output logic [7:0]     idx
);

    // Range check guards the occupancy lookup so an off-board index is never used.
    // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        idx   = cell_idx(row, col, N);
        legal = 1'b0;
        if (row < 4'(N) && col < 4'(N) && player == turn) begin
            legal = !(board_black[idx] || board_white[idx]);
        end
    end

endmodule

// File: rtl/gomoku_board_writer.sv
// Gomoku board owner: accepts moves, writes stones into per-player bitmaps,
// requests a win check on each placed stone and ends the game on win or draw.
module gomoku_board_writer
    import gomoku_pkg::*;
#(
    parameter int N       = BOARD_N,
    parameter int CHK_LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           mv_valid,
    output logic           mv_ready,
    input  logic [3:0]     mv_row,
    input  logic [3:0]     mv_col,
    input  logic           mv_player,
    output logic [N*N-1:0] board_black,
    output logic [N*N-1:0] board_white,
    output logic [3:0]     last_row,
    output logic [3:0]     last_col,
    output logic           chk_valid,
    input  logic           win_in,
    output logic           rej,
    output logic           turn,
    output logic [7:0]     move_cnt,
    output logic           game_over,
    output logic           win,
    output logic           winner
);

    state_t     state;
    state_t     state_next;
    logic [7:0] lat_cnt;
    logic       legal;
    logic [7:0] idx;
    logic       accept;
    logic       last_chk;
    logic       board_full;

    assign mv_ready   = (state == ST_IDLE);
    assign chk_valid  = (state == ST_CHECK);
    assign accept     = mv_valid && mv_ready;
    assign last_chk   = (lat_cnt == 8'(CHK_LAT));
    assign board_full = (move_cnt == 8'(N * N));

    gomoku_move_legal #(.N(N)) u_legal (
        .row         (mv_row),
        .col         (mv_col),
        .player      (mv_player),
        .turn        (turn),
        .board_black (board_black),
        .board_white (board_white),
        .legal       (legal),
        .idx         (idx)
    );

    // State register; clear returns to IDLE exactly like reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: legal accept starts a check; the check ends in DONE or back in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && legal) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (last_chk) begin
                    if (win_in || board_full) state_next = ST_DONE;
                    else                      state_next = ST_IDLE;
                end
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Board, last move, turn, counters and result flags.
    // NOTE: the bitmaps are reset too: clear must hand back an empty board, so they cannot be left uninitialised like a RAM.
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_black <= '0;
            board_white <= '0;
            last_row    <= '0;
            last_col    <= '0;
            rej         <= 1'b0;
            turn        <= PLAYER_BLACK;
            move_cnt    <= '0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            winner      <= 1'b0;
            lat_cnt     <= '0;
        end else if (clear) begin
            board_black <= '0;
            board_white <= '0;
            last_row    <= '0;
            last_col    <= '0;
            rej         <= 1'b0;
            turn        <= PLAYER_BLACK;
            move_cnt    <= '0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            winner      <= 1'b0;
            lat_cnt     <= '0;
        end else begin
            rej <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            if (mv_player == PLAYER_BLACK) board_black[idx] <= 1'b1;
                            else                           board_white[idx] <= 1'b1;
                            last_row <= mv_row;
                            last_col <= mv_col;
                            move_cnt <= move_cnt + 8'd1;
                            lat_cnt  <= '0;
                        end else begin
                            rej <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (last_chk) begin
                        if (win_in) begin
                            win       <= 1'b1;
                            winner    <= turn;
                            game_over <= 1'b1;
                        end else if (board_full) begin
                            game_over <= 1'b1;
                        end else begin
                            turn <= ~turn;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gomoku_board_writer.sv
// Self-checking bench for gomoku_board_writer: a directed move table applied
// to a combinational-checker instance and a CHK_LAT=2 instance, plus
// hand-written clear-during-check and full-board draw sequences.
module tb_gomoku_board_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         clear       [2];
    logic         mv_valid    [2];
    logic         mv_ready    [2];
    logic [3:0]   mv_row      [2];
    logic [3:0]   mv_col      [2];
    logic         mv_player   [2];
    logic [224:0] board_black [2];
    logic [224:0] board_white [2];
    logic [3:0]   last_row    [2];
    logic [3:0]   last_col    [2];
    logic         chk_valid   [2];
    logic         win_in      [2];
    logic         rej         [2];
    logic         turn        [2];
    logic [7:0]   move_cnt    [2];
    logic         game_over   [2];
    logic         win         [2];
    logic         winner      [2];

    // Checker stand-in: win_in is valid only on the last chk_valid cycle.
    logic win_arm [2];
    int   chk_cyc [2];
    int   lat_of  [2];

    always @(posedge clk) begin
        chk_cyc[0] <= chk_valid[0] ? chk_cyc[0] + 1 : 0;
        chk_cyc[1] <= chk_valid[1] ? chk_cyc[1] + 1 : 0;
    end
    assign win_in[0] = win_arm[0] && chk_valid[0] && (chk_cyc[0] == 0);
    assign win_in[1] = win_arm[1] && chk_valid[1] && (chk_cyc[1] == 2);

    gomoku_board_writer #(.N(15), .CHK_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear[0]),
        .mv_valid(mv_valid[0]), .mv_ready(mv_ready[0]),
        .mv_row(mv_row[0]), .mv_col(mv_col[0]), .mv_player(mv_player[0]),
        .board_black(board_black[0]), .board_white(board_white[0]),
        .last_row(last_row[0]), .last_col(last_col[0]),
        .chk_valid(chk_valid[0]), .win_in(win_in[0]), .rej(rej[0]),
        .turn(turn[0]), .move_cnt(move_cnt[0]), .game_over(game_over[0]),
        .win(win[0]), .winner(winner[0])
    );

    gomoku_board_writer #(.N(15), .CHK_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .clear(clear[1]),
        .mv_valid(mv_valid[1]), .mv_ready(mv_ready[1]),
        .mv_row(mv_row[1]), .mv_col(mv_col[1]), .mv_player(mv_player[1]),
        .board_black(board_black[1]), .board_white(board_white[1]),
        .last_row(last_row[1]), .last_col(last_col[1]),
        .chk_valid(chk_valid[1]), .win_in(win_in[1]), .rej(rej[1]),
        .turn(turn[1]), .move_cnt(move_cnt[1]), .game_over(game_over[1]),
        .win(win[1]), .winner(winner[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one move, return at T+1 (+1ns) with mv_valid dropped.
    task automatic do_move(input int d, input logic [3:0] r, input logic [3:0] c, input logic p);
        @(negedge clk);
        mv_row[d]    = r;
        mv_col[d]    = c;
        mv_player[d] = p;
        mv_valid[d]  = 1'b1;
        @(posedge clk);
        #1;
        mv_valid[d] = 1'b0;
    endtask

    // Count chk_valid cycles from the current cycle until it drops (bounded).
    task automatic wait_check(input int d, output int n);
        n = 0;
        while (chk_valid[d] && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear(input int d);
        @(negedge clk);
        clear[d] = 1'b1;
        @(posedge clk);
        #1;
        clear[d] = 1'b0;
    endtask

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic       player;
        logic       arm;
        logic       legal;
        logic       exp_rej;
        logic       exp_turn;
        logic [7:0] exp_cnt;
        logic       exp_over;
        logic       exp_win;
    } vec_t;

    vec_t vecs [14];

    logic [224:0] mb [2];
    logic [224:0] mw [2];
    logic [3:0]   mr [2];
    logic [3:0]   mc [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_chk;
        int idx;
        logic rej_seen;
        string tag;

        lat_of[0] = 0;
        lat_of[1] = 2;
        //           row  col  p  arm lg rej trn cnt ovr win
        vecs[0]  = '{4'd1,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[1]  = '{4'd1,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[2]  = '{4'd2,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[3]  = '{4'd15, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[4]  = '{4'd3,  4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[5]  = '{4'd0,  4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0};
        vecs[6]  = '{4'd2,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        vecs[7]  = '{4'd1,  4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0};
        vecs[8]  = '{4'd3,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0};
        vecs[9]  = '{4'd2,  4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0, 1'b0};
        vecs[10] = '{4'd4,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0};
        vecs[11] = '{4'd3,  4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8, 1'b0, 1'b0};
        vecs[12] = '{4'd5,  4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 1'b1, 1'b1};
        vecs[13] = '{4'd6,  4'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b1};

        for (int d = 0; d < 2; d++) begin
            clear[d] = 1'b0; mv_valid[d] = 1'b0; mv_row[d] = '0; mv_col[d] = '0;
            mv_player[d] = 1'b0; win_arm[d] = 1'b0;
            mb[d] = '0; mw[d] = '0; mr[d] = '0; mc[d] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset mv_ready", d), 256'(mv_ready[d]), 256'(1));
            check($sformatf("d%0d reset chk_valid", d), 256'(chk_valid[d]), 256'(0));
            check($sformatf("d%0d reset move_cnt", d), 256'(move_cnt[d]), 256'(0));
            check($sformatf("d%0d reset boards", d), 256'(board_black[d] | board_white[d]), 256'(0));
            check($sformatf("d%0d reset turn/over/win/rej", d),
                  256'({turn[d], game_over[d], win[d], rej[d]}), 256'(0));
        end

        // Directed move table: first move, occupied/out-of-range/wrong-turn rejects, column-of-five win.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 14; i++) begin
                tag = $sformatf("d%0d v%0d", d, i);
                win_arm[d] = vecs[i].arm;
                do_move(d, vecs[i].row, vecs[i].col, vecs[i].player);
                if (vecs[i].legal) begin
                    idx = int'(vecs[i].row) * 15 + int'(vecs[i].col);
                    if (vecs[i].player) mw[d][idx] = 1'b1;
                    else                mb[d][idx] = 1'b1;
                    mr[d] = vecs[i].row;
                    mc[d] = vecs[i].col;
                end
                check({tag, " rej"}, 256'(rej[d]), 256'(vecs[i].exp_rej));
                check({tag, " chk_valid"}, 256'(chk_valid[d]), 256'(vecs[i].legal));
                check({tag, " board_black"}, 256'(board_black[d]), 256'(mb[d]));
                check({tag, " board_white"}, 256'(board_white[d]), 256'(mw[d]));
                check({tag, " last_row/col"}, 256'({last_row[d], last_col[d]}), 256'({mr[d], mc[d]}));
                wait_check(d, n_chk);
                win_arm[d] = 1'b0;
                check({tag, " chk cycles"}, 256'(n_chk), vecs[i].legal ? 256'(lat_of[d] + 1) : 256'(0));
                check({tag, " turn"}, 256'(turn[d]), 256'(vecs[i].exp_turn));
                check({tag, " move_cnt"}, 256'(move_cnt[d]), 256'(vecs[i].exp_cnt));
                check({tag, " game_over"}, 256'(game_over[d]), 256'(vecs[i].exp_over));
                check({tag, " win"}, 256'(win[d]), 256'(vecs[i].exp_win));
                check({tag, " mv_ready"}, 256'(mv_ready[d]), 256'(!vecs[i].exp_over));
                if (vecs[i].exp_win) check({tag, " winner"}, 256'(winner[d]), 256'(0));
                @(posedge clk);
                #1;
                check({tag, " rej one cycle"}, 256'(rej[d]), 256'(0));
            end
        end

        // Clear during the check cycle while the checker reports a win.
        pulse_clear(0);
        check("clr new game mv_ready", 256'(mv_ready[0]), 256'(1));
        check("clr new game move_cnt", 256'(move_cnt[0]), 256'(0));
        win_arm[0] = 1'b1;
        do_move(0, 4'd7, 4'd7, 1'b0);
        check("clr chk_valid before clear", 256'(chk_valid[0]), 256'(1));
        check("clr board before clear", 256'(board_black[0][7*15+7]), 256'(1));
        clear[0] = 1'b1;
        @(posedge clk);
        #1;
        clear[0] = 1'b0;
        win_arm[0] = 1'b0;
        check("clr win", 256'(win[0]), 256'(0));
        check("clr game_over", 256'(game_over[0]), 256'(0));
        check("clr boards", 256'(board_black[0] | board_white[0]), 256'(0));
        check("clr turn", 256'(turn[0]), 256'(0));
        check("clr mv_ready", 256'(mv_ready[0]), 256'(1));
        check("clr move_cnt", 256'(move_cnt[0]), 256'(0));
        check("clr chk_valid", 256'(chk_valid[0]), 256'(0));

        // Fill the whole board with no winner: cell k gets player k%2.
        rej_seen = 1'b0;
        for (int k = 0; k < 225; k++) begin
            do_move(0, 4'(k / 15), 4'(k % 15), 1'(k % 2));
            rej_seen = rej_seen | rej[0];
            wait_check(0, n_chk);
            if (k == 223) begin
                check("fill 224 move_cnt", 256'(move_cnt[0]), 256'(224));
                check("fill 224 game_over", 256'(game_over[0]), 256'(0));
                check("fill 224 mv_ready", 256'(mv_ready[0]), 256'(1));
            end
        end
        check("fill rej seen", 256'(rej_seen), 256'(0));
        check("fill move_cnt", 256'(move_cnt[0]), 256'(225));
        check("fill game_over", 256'(game_over[0]), 256'(1));
        check("fill win", 256'(win[0]), 256'(0));
        check("fill mv_ready", 256'(mv_ready[0]), 256'(0));
        check("fill turn", 256'(turn[0]), 256'(0));
        check("fill board_black | board_white", 256'(board_black[0] | board_white[0]), 256'({225{1'b1}}));
        check("fill board_black & board_white", 256'(board_black[0] & board_white[0]), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
